multiplicador_secuencial: RTL

//  Unsigned shift-and-add multiplier, one partial product per clock.

---
 rtl/multiplicador_secuencial_pkg.sv | 21 ++
 rtl/multiplicador_secuencial_sumador.sv | 52 +++++
 rtl/multiplicador_secuencial.sv | 115 +++++++++++
 3 files changed

// File: rtl/multiplicador_secuencial_pkg.sv
// -----------------------------------------------------------------------------
// multiplicador_secuencial_pkg
//   Shared definitions for the sequential shift-and-add multiplier:
//   FSM state encoding and a helper for sizing the iteration counter.
// -----------------------------------------------------------------------------
package multiplicador_secuencial_pkg;

   // Encoding 2'd3 is unused; the FSM recovers from it to REPOSO.
   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      CALCULO = 2'd1,
      FIN     = 2'd2
   } estado_t;

   // Counter must hold the value ancho itself, so it never wraps
   // within an operation.
   function automatic int ancho_cuenta(input int ancho);
      return $clog2(ancho + 1);
   endfunction

endpackage : multiplicador_secuencial_pkg

// File: rtl/multiplicador_secuencial_sumador.sv
// -----------------------------------------------------------------------------
// Sumador_Completo / sumador_ripple_n
//   One-bit full adder and an N-bit ripple-carry adder built from it.
//   The multiplier uses the ripple adder to accumulate the multiplicand
//   into the upper half of the partial product.
//
// Ports (sumador_ripple_n):
//   X, Y            in   ANCHO  addends
//   AcarreoEntrada  in   1      carry in
//   Salida          out  ANCHO  sum
//   AcarreoSalida   out  1      carry out of the most significant bit
// -----------------------------------------------------------------------------
module Sumador_Completo (
   input  logic X,
   input  logic Y,
   input  logic AcarreoEntrada,
   output logic Salida,
   output logic AcarreoSalida
);

   assign Salida        = X ^ Y ^ AcarreoEntrada;
   assign AcarreoSalida = (X & Y) | (AcarreoEntrada & (X ^ Y));

endmodule : Sumador_Completo

module sumador_ripple_n #(
   parameter int ANCHO = 4
) (
   input  logic [ANCHO-1:0] X,
   input  logic [ANCHO-1:0] Y,
   input  logic             AcarreoEntrada,
   output logic [ANCHO-1:0] Salida,
   output logic             AcarreoSalida
);

   logic [ANCHO:0] acarreo;

   assign acarreo[0] = AcarreoEntrada;

   for (genvar i = 0; i < ANCHO; i++) begin : g_bit
      Sumador_Completo u_fa (
         .X              (X[i]),
         .Y              (Y[i]),
         .AcarreoEntrada (acarreo[i]),
         .Salida         (Salida[i]),
         .AcarreoSalida  (acarreo[i+1])
      );
   end

   assign AcarreoSalida = acarreo[ANCHO];

endmodule : sumador_ripple_n

// File: rtl/multiplicador_secuencial.sv
// -----------------------------------------------------------------------------
// multiplicador_secuencial
//   Unsigned shift-and-add multiplier, one partial product per clock.
//   The multiplier operand B sits in the low half of Producto and is
//   consumed LSB-first as the product shifts right; the multiplicand is
//   added into the high half through a ripple adder whenever the current
//   LSB is 1. Producto holds its final value until the next accepted start.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   REPOSO  | idle, waiting for Inicio; Producto holds last result
//   CALCULO | one add/shift iteration per clock, ANCHO iterations total
//   FIN     | Listo high for this single cycle, then back to REPOSO
//
// Ports:
//   Reloj     in   1        clock, rising edge
//   Reset_n   in   1        asynchronous active-low reset
//   Inicio    in   1        start request, sampled only in REPOSO
//   A         in   ANCHO    multiplicand, latched on accepted start
//   B         in   ANCHO    multiplier, latched on accepted start
//   Ocupado   out  1        high while not in REPOSO
//   Listo     out  1        one-cycle pulse, Producto valid
//   Producto  out  2*ANCHO  unsigned A*B
// -----------------------------------------------------------------------------
module multiplicador_secuencial
   import multiplicador_secuencial_pkg::*;
#(
   parameter int ANCHO = 4
) (
   input  logic               Reloj,
   input  logic               Reset_n,
   input  logic               Inicio,
   input  logic [ANCHO-1:0]   A,
   input  logic [ANCHO-1:0]   B,
   output logic               Ocupado,
   output logic               Listo,
   output logic [2*ANCHO-1:0] Producto
);

   localparam int CW = ancho_cuenta(ANCHO);

   estado_t             estado;
   estado_t             estado_sig;
   logic [CW-1:0]       cuenta;
   logic [ANCHO-1:0]    mcand;
   logic [2*ANCHO-1:0]  producto_q;

   logic [ANCHO-1:0]    sumando;
   logic [ANCHO-1:0]    suma;
   logic                acarreo;
   logic                ultima;

   // Adds zero when the current multiplier bit is 0, so the shift path
   // is the same for both cases.
   assign sumando = producto_q[0] ? mcand : '0;

   sumador_ripple_n #(
      .ANCHO (ANCHO)
   ) u_sumador (
      .X              (producto_q[2*ANCHO-1:ANCHO]),
      .Y              (sumando),
      .AcarreoEntrada (1'b0),
      .Salida         (suma),
      .AcarreoSalida  (acarreo)
   );

   assign ultima = (cuenta == CW'(ANCHO - 1));

   always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
         estado <= REPOSO;
      end else begin
         estado <= estado_sig;
      end
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         REPOSO:  if (Inicio) estado_sig = CALCULO;
         CALCULO: if (ultima) estado_sig = FIN;
         FIN:     estado_sig = REPOSO;
         default: estado_sig = REPOSO;
      endcase
   end

   always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
         cuenta     <= '0;
         mcand      <= '0;
         producto_q <= '0;
      end else begin
         case (estado)
            REPOSO: begin
               if (Inicio) begin
                  mcand      <= A;
                  producto_q <= {{ANCHO{1'b0}}, B};
                  cuenta     <= '0;
               end
            end
            CALCULO: begin
               // Carry-out lands in the MSB after the shift: no overflow.
               producto_q <= {acarreo, suma, producto_q[ANCHO-1:1]};
               cuenta     <= cuenta + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign Ocupado  = (estado != REPOSO);
   assign Listo    = (estado == FIN);
   assign Producto = producto_q;

endmodule : multiplicador_secuencial
